// File: rtl/ntt_seq_pkg.sv
// ntt_seq_pkg
//   Shared definitions for the NTT job sequencer: Kyber modulus, default
//   polynomial size, sequencer state encoding, error codes and a small
//   coefficient range helper.
package ntt_seq_pkg;

   localparam int KYBER_Q     = 3329;
   localparam int N_PAIRS_DEF = 128;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LOAD = 3'd1,
      KICK = 3'd2,
      RUN  = 3'd3,
      DONE = 3'd4,
      ERR  = 3'd5
   } state_t;

   localparam logic [1:0] ERR_NONE    = 2'b00;
   localparam logic [1:0] ERR_TIMEOUT = 2'b01;
   localparam logic [1:0] ERR_COUNT   = 2'b10;
   localparam logic [1:0] ERR_RANGE   = 2'b11;

   // A coefficient is legal only when fully reduced modulo q.
   function automatic logic coef_out_of_range(input logic [15:0] coef);
      return coef >= 16'(KYBER_Q);
   endfunction

endpackage

// File: rtl/ntt_seq_timer.sv
// ntt_seq_timer
//   Loadable down-counter shared by the core-reset hold and the run timeout.
//   Ports:
//     clk, rst_n  clock, asynchronous active-low reset
//     load        load 'value' into the counter (wins over en)
//     value       reload value; expiry happens 'value' enabled cycles after load
//     en          decrement while non-zero
//     expired     counter is zero
module ntt_seq_timer #(
   parameter int W = 13
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] value,
   input  logic         en,
   output logic         expired
);

   logic [W-1:0] cnt;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values, independent of process evaluation order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= value;
      end else if (en && (cnt != '0)) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign expired = (cnt == '0);

endmodule

// File: rtl/ntt_job_sequencer.sv
// ntt_job_sequencer
//   Host-facing sequencer for the single-butterfly Kyber NTT/INTT core.
//   Accepts one job command, streams N_PAIRS packed coefficient pairs into
//   the core RAM, holds the core in reset, launches it, counts FIFO write
//   strobes and reports done / error, with a cycle timeout while running.
//   Optional build macro: NTT_SEQ_RANGE_CHECK_EN -- flags any loaded
//   coefficient >= KYBER_Q and ends the job with error code 11 after the
//   last pair instead of launching the core.
//   Ports:
//     clk, rst_n                 clock, asynchronous active-low reset
//     cmd_valid/cmd_ready        job request handshake, cmd_mode 0=NTT 1=INTT
//     in_valid/in_ready/in_data  coefficient pair stream {coef_a, coef_b}
//     core_start, core_we        RAM load select and write enable
//     core_addr_a/b, core_data_a/b  RAM write port (2k, 2k+1)
//     core_rst, core_mode        active-high core reset, latched mode
//     core_done, core_wr_req     core completion level and FIFO write strobe
//     busy, job_done, err, err_code  job status
module ntt_job_sequencer
   import ntt_seq_pkg::*;
#(
   parameter int N_PAIRS    = N_PAIRS_DEF,
   parameter int RST_CYCLES = 2,
   parameter int TIMEOUT    = 4096,
   parameter int TO_W       = 13
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_mode,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_data,
   output logic        core_start,
   output logic        core_we,
   output logic [7:0]  core_addr_a,
   output logic [7:0]  core_addr_b,
   output logic [15:0] core_data_a,
   output logic [15:0] core_data_b,
   output logic        core_rst,
   output logic        core_mode,
   input  logic        core_done,
   input  logic        core_wr_req,
   output logic        busy,
   output logic        job_done,
   output logic        err,
   output logic [1:0]  err_code
);

   localparam logic [6:0]      K_LAST   = 7'(N_PAIRS - 1);
   localparam logic [7:0]      CNT_FULL = 8'(N_PAIRS);
   localparam logic [TO_W-1:0] RST_LOAD = TO_W'(RST_CYCLES - 1);
   localparam logic [TO_W-1:0] TO_LOAD  = TO_W'(TIMEOUT - 1);

   state_t          state, state_nx;
   logic [6:0]      k;
   logic [7:0]      out_cnt;
   logic            mode_q;
   logic            err_q;
   logic [1:0]      err_code_q;
   logic            done_q;
   logic            range_pend;

   logic            hs_cmd, hs_in, last_pair, done_rise;
   logic            pair_bad, range_fail;
   logic            tmr_load, tmr_en, tmr_expired;
   logic [TO_W-1:0] tmr_value;
   logic            err_set;
   logic [1:0]      err_set_code;

   assign hs_cmd    = (state == IDLE) && cmd_valid;
   assign hs_in     = (state == LOAD) && in_valid;
   assign last_pair = hs_in && (k == K_LAST);
   // done_q makes completion edge-triggered so a level left high cannot
   // complete a job twice.
   assign done_rise = core_done && !done_q;

`ifdef NTT_SEQ_RANGE_CHECK_EN
   assign pair_bad = hs_in && (coef_out_of_range(in_data[31:16]) ||
                               coef_out_of_range(in_data[15:0]));
`else
   assign pair_bad = 1'b0;
`endif
   // The offending pair may be the last one, so include it directly.
   assign range_fail = last_pair && (range_pend || pair_bad);

   ntt_seq_timer #(.W(TO_W)) u_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (tmr_load),
      .value   (tmr_value),
      .en      (tmr_en),
      .expired (tmr_expired)
   );

   // NOTE: every signal driven here gets a default first so no path leaves
   // it unassigned, which would otherwise infer a latch.
   always_comb begin
      state_nx     = state;
      tmr_load     = 1'b0;
      tmr_value    = '0;
      tmr_en       = 1'b0;
      err_set      = 1'b0;
      err_set_code = ERR_NONE;
      case (state)
         IDLE: if (cmd_valid) state_nx = LOAD;
         LOAD: begin
            if (last_pair) begin
               if (range_fail) begin
                  state_nx     = ERR;
                  err_set      = 1'b1;
                  err_set_code = ERR_RANGE;
               end else begin
                  state_nx  = KICK;
                  tmr_load  = 1'b1;
                  tmr_value = RST_LOAD;
               end
            end
         end
         KICK: begin
            tmr_en = 1'b1;
            if (tmr_expired) begin
               state_nx  = RUN;
               tmr_load  = 1'b1;
               tmr_value = TO_LOAD;
            end
         end
         RUN: begin
            tmr_en = 1'b1;
            // Completion is checked first so it wins over a coincident timeout.
            if (done_rise) begin
               if (out_cnt == CNT_FULL) begin
                  state_nx = DONE;
               end else begin
                  state_nx     = ERR;
                  err_set      = 1'b1;
                  err_set_code = ERR_COUNT;
               end
            end else if (tmr_expired) begin
               state_nx     = ERR;
               err_set      = 1'b1;
               err_set_code = ERR_TIMEOUT;
            end
         end
         DONE:    state_nx = IDLE;
         ERR:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         k          <= '0;
         out_cnt    <= '0;
         mode_q     <= 1'b0;
         err_q      <= 1'b0;
         err_code_q <= ERR_NONE;
         done_q     <= 1'b0;
         range_pend <= 1'b0;
      end else begin
         state  <= state_nx;
         done_q <= core_done;
         if (hs_cmd) begin
            mode_q     <= cmd_mode;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
            k          <= '0;
            out_cnt    <= '0;
            range_pend <= 1'b0;
         end
         if (hs_in) begin
            k <= k + 1'b1;
            if (pair_bad) range_pend <= 1'b1;
         end
         if ((state == RUN) && core_wr_req && (out_cnt != 8'hFF)) begin
            out_cnt <= out_cnt + 1'b1;
         end
         if (err_set) begin
            err_q      <= 1'b1;
            err_code_q <= err_set_code;
         end
      end
   end

   assign cmd_ready   = (state == IDLE);
   assign in_ready    = (state == LOAD);
   assign core_start  = (state == LOAD);
   assign core_we     = hs_in;
   // Addresses and data are forced to zero outside LOAD so the RAM port is
   // quiet whenever the host is not loading.
   assign core_addr_a = in_ready ? {k, 1'b0} : 8'd0;
   assign core_addr_b = in_ready ? {k, 1'b1} : 8'd0;
   assign core_data_a = in_ready ? in_data[31:16] : 16'd0;
   assign core_data_b = in_ready ? in_data[15:0]  : 16'd0;
   assign core_rst    = (state == KICK) || (state == ERR);
   assign core_mode   = mode_q;
   assign busy        = (state != IDLE);
   assign job_done    = (state == DONE);
   assign err         = err_q;
   assign err_code    = err_code_q;

endmodule

// File: tb/tb_ntt_job_sequencer.sv
// tb_ntt_job_sequencer
//   Self-checking bench for ntt_job_sequencer. A job-level reference model
//   predicts every output each cycle; literal expectations pin write counts,
//   addresses, reset lengths and error codes for the directed jobs.
//   Honours NTT_SEQ_RANGE_CHECK_EN for the range-violation job.
module tb_ntt_job_sequencer;

   localparam int NP   = 128;
   localparam int RSTC = 2;
   localparam int TMO  = 300;
   localparam int Q    = 3329;
`ifdef NTT_SEQ_RANGE_CHECK_EN
   localparam bit RANGE_ON = 1'b1;
`else
   localparam bit RANGE_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cmd_valid = 1'b0, cmd_mode = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] in_data = '0;
   logic        core_done = 1'b0, core_wr_req = 1'b0;
   logic        cmd_ready, in_ready, core_start, core_we, core_rst, core_mode;
   logic [7:0]  core_addr_a, core_addr_b;
   logic [15:0] core_data_a, core_data_b;
   logic        busy, job_done, err;
   logic [1:0]  err_code;

   always #5 clk = ~clk;

   ntt_job_sequencer #(
      .N_PAIRS(NP), .RST_CYCLES(RSTC), .TIMEOUT(TMO), .TO_W(13)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .core_start(core_start), .core_we(core_we),
      .core_addr_a(core_addr_a), .core_addr_b(core_addr_b),
      .core_data_a(core_data_a), .core_data_b(core_data_b),
      .core_rst(core_rst), .core_mode(core_mode),
      .core_done(core_done), .core_wr_req(core_wr_req),
      .busy(busy), .job_done(job_done), .err(err), .err_code(err_code)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model (job phases, plain counters) --------
   localparam int PH_IDLE = 0, PH_LOAD = 1, PH_HOLD = 2, PH_RUN = 3, PH_OK = 4, PH_FAIL = 5;
   int         ph;
   int         m_pairs, m_hold, m_age, m_wrs;
   bit         m_mode, m_err, m_bad, m_done_prev;
   logic [1:0] m_code;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ph = PH_IDLE; m_pairs = 0; m_hold = 0; m_age = 0; m_wrs = 0;
         m_mode = 0; m_err = 0; m_bad = 0; m_done_prev = 0; m_code = 2'd0;
      end else begin
         case (ph)
            PH_IDLE: if (cmd_valid) begin
               m_mode = cmd_mode; m_err = 0; m_code = 2'd0;
               m_pairs = 0; m_wrs = 0; m_bad = 0; ph = PH_LOAD;
            end
            PH_LOAD: if (in_valid) begin
               if (RANGE_ON && ((int'(in_data[31:16]) >= Q) || (int'(in_data[15:0]) >= Q)))
                  m_bad = 1;
               m_pairs++;
               if (m_pairs == NP) begin
                  if (m_bad) begin ph = PH_FAIL; m_err = 1; m_code = 2'd3; end
                  else begin ph = PH_HOLD; m_hold = 0; end
               end
            end
            PH_HOLD: begin
               m_hold++;
               if (m_hold == RSTC) begin ph = PH_RUN; m_age = 0; end
            end
            PH_RUN: begin
               m_age++;
               if (core_done && !m_done_prev) begin
                  if (m_wrs == NP) ph = PH_OK;
                  else begin ph = PH_FAIL; m_err = 1; m_code = 2'd2; end
               end else if (m_age == TMO) begin
                  ph = PH_FAIL; m_err = 1; m_code = 2'd1;
               end
               if (core_wr_req && m_wrs < 255) m_wrs++;
            end
            default: ph = PH_IDLE;
         endcase
         m_done_prev = core_done;
      end
   end

   // ---------------- per-cycle compare + activity monitors ---------------
   int we_total = 0, rst_total = 0, done_total = 0, run_total = 0;
   logic [7:0] last_a = '0, last_b = '0;

   always @(negedge clk) begin
      check("cmd_ready",  32'(cmd_ready),  32'(ph == PH_IDLE));
      check("in_ready",   32'(in_ready),   32'(ph == PH_LOAD));
      check("core_start", 32'(core_start), 32'(ph == PH_LOAD));
      check("core_we",    32'(core_we),    32'(ph == PH_LOAD && in_valid));
      check("addr_a",     32'(core_addr_a), (ph == PH_LOAD) ? 32'(2 * m_pairs) : 32'd0);
      check("addr_b",     32'(core_addr_b), (ph == PH_LOAD) ? 32'(2 * m_pairs + 1) : 32'd0);
      if (ph == PH_LOAD) begin
         if (in_valid) begin
            check("data_a", 32'(core_data_a), 32'(in_data[31:16]));
            check("data_b", 32'(core_data_b), 32'(in_data[15:0]));
         end
      end else begin
         check("data_a_idle", 32'(core_data_a), 32'd0);
         check("data_b_idle", 32'(core_data_b), 32'd0);
      end
      check("core_rst",  32'(core_rst),  32'(ph == PH_HOLD || ph == PH_FAIL));
      check("core_mode", 32'(core_mode), 32'(m_mode));
      check("busy",      32'(busy),      32'(ph != PH_IDLE));
      check("job_done",  32'(job_done),  32'(ph == PH_OK));
      check("err",       32'(err),       32'(m_err));
      check("err_code",  32'(err_code),  32'(m_code));
      if (core_we) begin we_total++; last_a = core_addr_a; last_b = core_addr_b; end
      if (core_rst) rst_total++;
      if (job_done) done_total++;
      if (busy && !core_start && !core_rst && !job_done) run_total++;
   end

   // ---------------- stimulus ---------------------------------------------
   logic [31:0] pdata [NP];
   int we0, rst0, dn0, run0;

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic snap();
      we0 = we_total; rst0 = rst_total; dn0 = done_total; run0 = run_total;
   endtask

   task automatic fill_random(input int bad_idx);
      for (int i = 0; i < NP; i++)
         pdata[i] = {16'($urandom_range(Q - 1)), 16'($urandom_range(Q - 1))};
      if (bad_idx >= 0) pdata[bad_idx] = 32'h0D01_0000;
   endtask

   task automatic send_cmd(input bit mode);
      cmd_valid = 1'b1; cmd_mode = mode; tick();
      cmd_valid = 1'b0;
   endtask

   // stall: 0 back-to-back, 1 alternate valid 1/0, 2 random gaps.
   // churn: toggle cmd_valid/cmd_mode while loading (must be ignored).
   task automatic load_pairs(input int first, input int last, input int stall, input bit churn);
      for (int i = first; i <= last; i++) begin
         if ((stall == 1 && i > first) || (stall == 2 && $urandom_range(2) == 0)) begin
            in_valid = 1'b0; in_data = $urandom;
            if (churn) begin cmd_valid = 1'($urandom_range(1)); cmd_mode = 1'($urandom_range(1)); end
            tick();
         end
         in_valid = 1'b1; in_data = pdata[i];
         if (churn) begin cmd_valid = 1'($urandom_range(1)); cmd_mode = 1'($urandom_range(1)); end
         tick();
      end
      in_valid = 1'b0; cmd_valid = 1'b0;
   endtask

   // Acts as the NTT core: once launched, emits n_wr FIFO strobes and
   // optionally raises done.
   task automatic run_core(input int n_wr, input bit give_done);
      int guard = 0;
      while (busy && (core_start || core_rst) && guard < 50) begin tick(); guard++; end
      check("launch_bound", 32'(guard < 50), 32'd1);
      if (busy) begin
         for (int i = 0; i < n_wr; i++) begin
            if ($urandom_range(3) == 0) begin core_wr_req = 1'b0; tick(); end
            core_wr_req = 1'b1; tick();
         end
         core_wr_req = 1'b0;
         if (give_done) core_done = 1'b1;
      end
   endtask

   task automatic wait_idle(input int limit);
      int g = 0;
      while (busy && g < limit) begin tick(); g++; end
      check("job_end_bound", 32'(busy), 32'd0);
      core_done = 1'b0;
   endtask

   initial begin
      #2;
      check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      check("rst_busy",      32'(busy),      32'd0);
      check("rst_addr_b",    32'(core_addr_b), 32'd0);
      @(negedge clk); rst_n = 1'b1;
      tick();

      // Job A: NTT, back-to-back counting pattern
      snap();
      for (int i = 0; i < NP; i++) pdata[i] = {16'(i + 1), 16'(i + 2)};
      send_cmd(1'b0);
      load_pairs(0, NP - 1, 0, 1'b0);
      run_core(NP, 1'b1);
      wait_idle(TMO + 20);
      check("A_we_count", 32'(we_total - we0),   32'd128);
      check("A_last_a",   32'(last_a),           32'd254);
      check("A_last_b",   32'(last_b),           32'd255);
      check("A_rst_len",  32'(rst_total - rst0), 32'd2);
      check("A_job_done", 32'(done_total - dn0), 32'd1);
      check("A_err",      32'(err),              32'd0);

      // Job B: INTT, valid alternating, cmd_mode churning mid-job
      snap();
      fill_random(-1);
      send_cmd(1'b1);
      load_pairs(0, NP - 1, 1, 1'b1);
      check("B_mode_held", 32'(core_mode), 32'd1);
      run_core(NP, 1'b1);
      wait_idle(TMO + 20);
      check("B_we_count", 32'(we_total - we0),   32'd128);
      check("B_job_done", 32'(done_total - dn0), 32'd1);

      // Job C: timeout
      snap();
      fill_random(-1);
      send_cmd(1'b0);
      load_pairs(0, NP - 1, 0, 1'b0);
      run_core(20, 1'b0);
      wait_idle(TMO + 20);
      check("C_cmd_ready", 32'(cmd_ready),         32'd1);
      check("C_err",       32'(err),               32'd1);
      check("C_err_code",  32'(err_code),          32'd1);
      check("C_run_len",   32'(run_total - run0),  32'(TMO));
      check("C_rst_len",   32'(rst_total - rst0),  32'(RSTC + 1));
      check("C_no_done",   32'(done_total - dn0),  32'd0);

      // Job D: output count mismatch, then a good job clears err
      snap();
      fill_random(-1);
      send_cmd(1'b1);
      load_pairs(0, NP - 1, 2, 1'b1);
      run_core(NP - 1, 1'b1);
      wait_idle(TMO + 20);
      check("D_err_code", 32'(err_code),         32'd2);
      check("D_no_done",  32'(done_total - dn0), 32'd0);
      snap();
      fill_random(-1);
      send_cmd(1'b0);
      check("E_err_clear", 32'(err), 32'd0);
      load_pairs(0, NP - 1, 2, 1'b0);
      run_core(NP, 1'b1);
      wait_idle(TMO + 20);
      check("E_job_done", 32'(done_total - dn0), 32'd1);

      // Job F: out-of-range coefficient at pair 40
      snap();
      fill_random(40);
      send_cmd(1'b0);
      load_pairs(0, NP - 1, 0, 1'b0);
      run_core(NP, 1'b1);
      wait_idle(TMO + 20);
      check("F_we_count", 32'(we_total - we0),   32'd128);
      check("F_err_code", 32'(err_code),         RANGE_ON ? 32'd3 : 32'd0);
      check("F_job_done", 32'(done_total - dn0), RANGE_ON ? 32'd0 : 32'd1);
      check("F_rst_len",  32'(rst_total - rst0), RANGE_ON ? 32'd1 : 32'(RSTC));

      // Job G: asynchronous reset at k=50, then restart from address 0
      fill_random(-1);
      send_cmd(1'b1);
      load_pairs(0, 49, 0, 1'b0);
      in_valid = 1'b1; in_data = pdata[50];
      #2 rst_n = 1'b0;
      #1;
      check("G_cmd_ready", 32'(cmd_ready),   32'd1);
      check("G_in_ready",  32'(in_ready),    32'd0);
      check("G_start",     32'(core_start),  32'd0);
      check("G_we",        32'(core_we),     32'd0);
      check("G_addr_a",    32'(core_addr_a), 32'd0);
      check("G_data_a",    32'(core_data_a), 32'd0);
      check("G_core_rst",  32'(core_rst),    32'd0);
      check("G_mode",      32'(core_mode),   32'd0);
      check("G_busy",      32'(busy),        32'd0);
      in_valid = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      tick();
      snap();
      send_cmd(1'b0);
      in_valid = 1'b1; in_data = pdata[0];
      #1;
      check("G_first_we",     32'(core_we),     32'd1);
      check("G_first_addr_a", 32'(core_addr_a), 32'd0);
      check("G_first_addr_b", 32'(core_addr_b), 32'd1);
      tick();
      load_pairs(1, NP - 1, 2, 1'b1);
      run_core(NP, 1'b1);
      wait_idle(TMO + 20);
      check("G_job_done", 32'(done_total - dn0), 32'd1);

      // Random jobs: mixed outcomes, checked by the model only
      for (int j = 0; j < 4; j++) begin
         int kind;
         kind = $urandom_range(2);
         fill_random(-1);
         send_cmd(1'($urandom_range(1)));
         load_pairs(0, NP - 1, $urandom_range(2), 1'b1);
         if (kind == 0)      run_core(NP, 1'b1);
         else if (kind == 1) run_core($urandom_range(100, 127), 1'b1);
         else                run_core($urandom_range(10, 60), 1'b0);
         wait_idle(TMO + 20);
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
